// File: rtl/mult_pkg.sv
// Shared FSM encoding and counter sizing for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must represent WIDTH itself so it never wraps mid-operation.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple adder/subtractor: sum = x + (sub ? ~y + 1 : y), built from full-adder cells.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] yi;

  assign c[0] = sub;
  assign yi   = y ^ {WIDTH{sub}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (yi[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one partial product per clock, WIDTH steps per operation.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (final step subtracts).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand, hi, lo, sum, nhi;
  logic [CW-1:0]    cnt;
  logic             sub, cout, msb;

  adder_nbit #(.WIDTH(WIDTH)) u_add (
    .x    (hi),
    .y    (mcand),
    .sub  (sub),
    .sum  (sum),
    .cout (cout)
  );

  assign nhi = lo[0] ? sum : hi;

`ifdef SEQ_MULT_SIGNED_EN
  // Multiplier MSB carries negative weight; the shifted-in bit is the true
  // sign of the (WIDTH+1)-bit partial sum, recovered from the carry out.
  assign sub = (cnt == LAST);
  assign msb = lo[0] ? (hi[WIDTH-1] ^ mcand[WIDTH-1] ^ sub ^ cout) : hi[WIDTH-1];
`else
  assign sub = 1'b0;
  assign msb = lo[0] & cout;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi  <= {msb, nhi[WIDTH-1:1]};
          lo  <= {nhi[0], lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {msb, nhi, lo[WIDTH-1:1]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a multiplication; sampled only while busy=0.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand; captured on the accepted start edge.
REQ-006 SHALL have port: b  input  WIDTH  multiplier; captured on the accepted start edge.
REQ-007 SHALL have port: busy  output  1  high while a multiplication is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking product valid.
REQ-009 SHALL have port: product  output  2*WIDTH  result register.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and DONE.
- IDLE/DONE + start=1 -> CALC
- IDLE + start=0 -> IDLE
- DONE + start=0 -> IDLE
- CALC -> DONE after exactly WIDTH shift-add steps
REQ-011 SHALL accept start in both IDLE and DONE, so back-to-back operations lose no cycle.
REQ-012 SHALL ignore start while in CALC; the in-flight operation SHALL complete unaffected.
REQ-013 SHALL take operands only from the accepted start edge; later changes to a/b SHALL have no effect.
REQ-014 SHALL, in CALC, on each edge:
- add the multiplicand to the upper accumulator half when the current multiplier LSB is 1;
- shift the accumulator right one bit, capturing the adder carry.
REQ-015 SHALL size the step counter to ceil(log2(WIDTH+1)) bits, with no wrap before WIDTH steps complete.
REQ-016 SHALL assert busy exactly in CALC, and done exactly for the single cycle in DONE.
REQ-017 SHALL have fixed latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH.
REQ-018 SHALL update product only on the CALC->DONE edge; product SHALL hold its value until the next completion.
REQ-019 SHALL produce the exact full-width 2*WIDTH result; there is no truncation and no overflow.

Reset
REQ-020 SHALL, when rst_n=0 at a clock edge:
- set state to IDLE;
- clear busy, done, product, accumulator and counter to 0.
REQ-021 SHALL, on reset during CALC, abort the operation; no done pulse SHALL follow.
REQ-022 SHALL give reset priority over start when both are asserted on the same edge.

Configuration
REQ-023 SHALL support macro SEQ_MULT_SIGNED_EN.
- Defined: a, b and product are two's complement; the final step (multiplier MSB) subtracts the multiplicand instead of adding; accumulator shifts are arithmetic.
- Undefined: all operands are unsigned and shifts are logical.
REQ-024 SHALL keep latency and handshake identical in both builds.

Structure
REQ-025 SHALL place FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) in shared package mult_pkg.
REQ-026 SHALL place the counter-width function in mult_pkg.
REQ-027 SHALL instantiate one sub-module, adder_nbit: a WIDTH-bit ripple adder/subtractor built from the team's full-adder cell, with carry-in used for subtraction.

Verification
REQ-028 SHALL cover: WIDTH=4 unsigned, a=13, b=11, start pulse at edge 0 -> done high after edge 4, product=8'h8F, busy high edges 1..4.
REQ-029 SHALL cover: WIDTH=4, start held high through DONE with new a=15, b=15 -> second done exactly 5 cycles after the first, product=8'hE1.
REQ-030 SHALL cover: WIDTH=4, a=9, b=7, start re-pulsed with a=0 on edge 2 -> ignored, product=8'h3F.
REQ-031 SHALL cover: WIDTH=4, rst_n=0 on edge 2 of CALC -> busy=0, product=0, no done pulse; a fresh start then gives a correct result.
REQ-032 SHALL cover: WIDTH=8 unsigned, a=255, b=255 -> product=16'hFE01 after 8 cycles.
REQ-033 SHALL cover, with SEQ_MULT_SIGNED_EN, WIDTH=4:
- a=-3, b=5 -> product=8'hF1;
- a=-8, b=-8 -> product=8'h40.
